// File: rtl/pc_pkg.sv
// Shared next-PC source encodings and default vectors for the PC sequencer.
package pc_pkg;

   localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_JREG   = 2'b11;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer; a push while full
// overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic [WIDTH-1:0]            wdata_i,
   output logic [WIDTH-1:0]            top_o,
   output logic [$clog2(RAS_DEPTH):0]  count_o,
   output logic                        overflow_o
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;
   logic             full;
   logic             pop_hit;

   assign full    = (count_q == CNT_W'(RAS_DEPTH));
   assign pop_hit = pop_i && (count_q != '0);

   // Entry storage is deliberately not reset; the empty case is masked on top_o.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         if (push_i && pop_hit)
            mem_q[ptr_q] <= wdata_i;
         else if (push_i)
            mem_q[ptr_q + PTR_W'(1)] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (push_i && !pop_hit) begin
         ptr_q <= ptr_q + PTR_W'(1);
         if (full)
            overflow_q <= 1'b1;
         else
            count_q <= count_q + CNT_W'(1);
      end else if (pop_hit && !push_i) begin
         ptr_q   <= ptr_q - PTR_W'(1);
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign top_o      = (count_q == '0) ? '0 : mem_q[ptr_q];
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with next-PC selection, exception redirect, stall, and a
// return-address stack that predicts jr $ra targets.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
   parameter int               RAS_DEPTH    = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        stall_i,
   input  logic                        exc_req_i,
   input  logic [1:0]                  pc_src_i,
   input  logic                        ret_hint_i,
   input  logic                        link_i,
   input  logic [WIDTH-1:0]            branch_target_i,
   input  logic [WIDTH-1:0]            jump_target_i,
   input  logic [WIDTH-1:0]            jreg_target_i,
   output logic [WIDTH-1:0]            pc_out_o,
   output logic [WIDTH-1:0]            pc_plus4_o,
   output logic [WIDTH-1:0]            ras_top_o,
   output logic [$clog2(RAS_DEPTH):0]  ras_count_o,
   output logic                        ras_overflow_o,
   output logic                        ras_mispredict_o
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

   logic [WIDTH-1:0]           pc_q, pc_d;
   logic                       mispredict_q, mispredict_d;
   logic [WIDTH-1:0]           pc_plus4;
   logic [WIDTH-1:0]           ras_top;
   logic [$clog2(RAS_DEPTH):0] ras_count;
   logic                       advance, push, pop, pop_hit;

   assign pc_plus4 = pc_q + WIDTH'(4);
   assign advance  = !exc_req_i && !stall_i;
   assign push     = advance && link_i;
   assign pop      = advance && (pc_src_i == PC_SRC_JREG) && ret_hint_i;
   assign pop_hit  = pop && (ras_count != '0);

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .push_i     (push),
      .pop_i      (pop),
      .wdata_i    (pc_plus4),
      .top_o      (ras_top),
      .count_o    (ras_count),
      .overflow_o (ras_overflow_o)
   );

   always_comb begin
      pc_d = pc_plus4;
      unique case (pc_src_i)
         PC_SRC_SEQ:    pc_d = pc_plus4;
         PC_SRC_BRANCH: pc_d = branch_target_i;
         PC_SRC_JUMP:   pc_d = jump_target_i;
         PC_SRC_JREG:   pc_d = pop_hit ? ras_top : jreg_target_i;
         default:       pc_d = pc_plus4;
      endcase
      pc_d = pc_d & ALIGN_MASK;
   end

   // The PC still follows the prediction; the flag only tells control to recover.
   assign mispredict_d = pop_hit && (ras_top != (jreg_target_i & ALIGN_MASK));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q         <= RESET_VECTOR;
         mispredict_q <= 1'b0;
      end else if (exc_req_i) begin
         pc_q         <= EXC_VECTOR;
         mispredict_q <= 1'b0;
      end else if (stall_i) begin
         mispredict_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         mispredict_q <= mispredict_d;
      end
   end

   assign pc_out_o         = pc_q;
   assign pc_plus4_o       = pc_plus4;
   assign ras_top_o        = ras_top;
   assign ras_count_o      = ras_count;
   assign ras_mispredict_o = mispredict_q;

endmodule
